// File: rtl/sevenseg_scanner.sv
// Time-multiplexed hex display driver for DIGITS seven-segment digits.
// A free-running prescaler sets the slot length, a digit index walks the
// digits, and a shadow/display register pair keeps each frame tear-free.
// Every output leaves through a register with the board polarity applied.
module sevenseg_scanner #(
   parameter int DIGITS         = 4,
   parameter int DIV_BITS       = 14,
   parameter int DEAD_CYCLES    = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic                  lzb_en,
   output logic [6:0]            seg,
   output logic                  seg_dp,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [DIV_BITS-1:0] DEAD_LIM = DIV_BITS'(DEAD_CYCLES);
   localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_OFF   = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0]   DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   // Standard hex glyphs in active-high {g,f,e,d,c,b,a} form
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      case (nib)
         4'h0: hex_glyph = 7'b0111111;
         4'h1: hex_glyph = 7'b0000110;
         4'h2: hex_glyph = 7'b1011011;
         4'h3: hex_glyph = 7'b1001111;
         4'h4: hex_glyph = 7'b1100110;
         4'h5: hex_glyph = 7'b1101101;
         4'h6: hex_glyph = 7'b1111101;
         4'h7: hex_glyph = 7'b0000111;
         4'h8: hex_glyph = 7'b1111111;
         4'h9: hex_glyph = 7'b1101111;
         4'hA: hex_glyph = 7'b1110111;
         4'hB: hex_glyph = 7'b1111100;
         4'hC: hex_glyph = 7'b0111001;
         4'hD: hex_glyph = 7'b1011110;
         4'hE: hex_glyph = 7'b1111001;
         default: hex_glyph = 7'b1110001;
      endcase
   endfunction

   logic [DIV_BITS-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic                frame_tick_q, frame_tick_d;
   logic [6:0]          seg_q, seg_d;
   logic                seg_dp_q, seg_dp_d;
   logic [DIGITS-1:0]   digit_en_q, digit_en_d;

   logic                slot_tick;
   logic                wrap;
   logic [3:0]          nib;
   logic                dp_sel;
   logic                blank;
   logic                higher_zero;
   logic [DIGITS-1:0]   onehot;
   logic [DIGITS-1:0]   lit_en;
   logic [6:0]          glyph;

   // Scan timing and buffering: the display only changes on the wrap edge,
   // and a load landing on that same edge goes straight to the display
   always_comb begin
      slot_tick    = (presc_q == '1);
      wrap         = slot_tick && (idx_q == LAST_IDX);
      presc_d      = presc_q + DIV_BITS'(1);
      idx_d        = idx_q;
      if (wrap)
         idx_d = '0;
      else if (slot_tick)
         idx_d = idx_q + IDX_W'(1);
      shadow_val_d = load ? value : shadow_val_q;
      shadow_dp_d  = load ? dp    : shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      if (wrap) begin
         disp_val_d = load ? value : shadow_val_q;
         disp_dp_d  = load ? dp    : shadow_dp_q;
      end
      frame_tick_d = wrap;
   end

   // Digit selection, leading-zero blanking, dead time and output polarity
   always_comb begin
      nib         = 4'h0;
      dp_sel      = 1'b0;
      blank       = 1'b0;
      onehot      = '0;
      higher_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         higher_zero = higher_zero && (disp_val_q[4*i +: 4] == 4'h0);
         if (idx_q == IDX_W'(i)) begin
            nib       = disp_val_q[4*i +: 4];
            dp_sel    = disp_dp_q[i];
            onehot[i] = 1'b1;
            blank     = lzb_en && (i != 0) && higher_zero;
         end
      end
      glyph      = blank ? 7'h00 : hex_glyph(nib);
      lit_en     = (presc_q < DEAD_LIM) ? '0 : onehot;
      seg_d      = (SEG_ACTIVE_LOW != 0) ? ~glyph  : glyph;
      seg_dp_d   = (SEG_ACTIVE_LOW != 0) ? ~dp_sel : dp_sel;
      digit_en_d = (DIG_ACTIVE_LOW != 0) ? ~lit_en : lit_en;
   end

   // State and output registers; reset parks everything with the display dark
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         frame_tick_q <= 1'b0;
         seg_q        <= SEG_OFF;
         seg_dp_q     <= DP_OFF;
         digit_en_q   <= DIG_OFF;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         frame_tick_q <= frame_tick_d;
         seg_q        <= seg_d;
         seg_dp_q     <= seg_dp_d;
         digit_en_q   <= digit_en_d;
      end
   end

   assign seg        = seg_q;
   assign seg_dp     = seg_dp_q;
   assign digit_en   = digit_en_q;
   assign frame_tick = frame_tick_q;

endmodule
